// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for seven_seg_scan: scan control and frame data in,
// segment/digit pins and the frame tick out.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_blank;
  logic [7:0]              segment;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_tick;

  modport master (
    output en, load, digits_in, dp_in, lz_blank,
    input  segment, digit_sel, frame_tick
  );

  modport slave (
    input  en, load, digits_in, dp_in, lz_blank,
    output segment, digit_sel, frame_tick
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered frame
// data, per-digit decimal points and leading-zero blanking.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 50000,
  parameter int HEX_EN      = 0,
  parameter int SEL_ACT_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  seven_seg_scan_if.slave  bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACT_LOW != 0}};

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_codes;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_disp_codes;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [7:0]              r_segment;
  logic [NUM_DIGITS-1:0]   r_digit_sel;
  logic                    r_frame_tick;

  logic                    w_cnt_wrap;
  logic                    w_frame_wrap;
  logic [3:0]              w_cur_code;
  logic                    w_cur_dp;
  logic                    w_cur_lead;
  logic [NUM_DIGITS-1:0]   w_sel_onehot;
  logic [NUM_DIGITS-1:0]   w_lead;
  logic                    w_run;
  logic                    w_lz_dark;
  logic [7:0]              w_decoded;

  function automatic logic [7:0] f_decode(input logic [3:0] code);
    logic [7:0] seg;
    seg = 8'hFF;
    case (code)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      default: begin
        if (HEX_EN != 0) begin
          case (code)
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
          endcase
        end
      end
    endcase
    return seg;
  endfunction

  assign w_cnt_wrap   = (r_cnt == CNT_MAX);
  assign w_frame_wrap = w_cnt_wrap && (r_idx == IDX_MAX);

  // w_lead[i]: digits i..top are all zero with no dp lit, walked from the top
  // so a dp-lit zero stops suppression for everything below it.
  always_comb begin
    w_lead = '0;
    w_run  = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      w_run = w_run && (r_disp_codes[4*(NUM_DIGITS-1-j) +: 4] == 4'd0)
                    && !r_disp_dp[NUM_DIGITS-1-j];
      w_lead[NUM_DIGITS-1-j] = w_run;
    end
  end

  always_comb begin
    w_cur_code   = '0;
    w_cur_dp     = 1'b0;
    w_cur_lead   = 1'b0;
    w_sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_code      = r_disp_codes[4*i +: 4];
        w_cur_dp        = r_disp_dp[i];
        w_cur_lead      = w_lead[i];
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  assign w_lz_dark = bus.lz_blank && w_cur_lead && (r_idx != '0);
  assign w_decoded = f_decode(w_cur_code);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend_codes <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_disp_codes <= '0;
      r_disp_dp    <= '0;
      r_segment    <= '1;
      r_digit_sel  <= SEL_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;

      if (bus.load) begin
        r_pend_codes <= bus.digits_in;
        r_pend_dp    <= bus.dp_in;
        r_pend_valid <= 1'b1;
      end

      if (!bus.en) begin
        r_cnt       <= '0;
        r_idx       <= '0;
        r_segment   <= '1;
        r_digit_sel <= SEL_OFF;
      end else begin
        if (r_cnt == '0) begin
          r_segment   <= '1;
          r_digit_sel <= SEL_OFF;
        end else begin
          r_digit_sel <= (SEL_ACT_LOW != 0) ? ~w_sel_onehot : w_sel_onehot;
          r_segment   <= w_lz_dark ? 8'hFF : {~w_cur_dp, w_decoded[6:0]};
        end

        if (w_frame_wrap) begin
          r_cnt        <= '0;
          r_idx        <= '0;
          r_frame_tick <= 1'b1;
          // A load on the commit edge bypasses pending so its data is shown.
          if (bus.load) begin
            r_disp_codes <= bus.digits_in;
            r_disp_dp    <= bus.dp_in;
          end else if (r_pend_valid) begin
            r_disp_codes <= r_pend_codes;
            r_disp_dp    <= r_pend_dp;
          end
          r_pend_valid <= 1'b0;
        end else if (w_cnt_wrap) begin
          r_cnt <= '0;
          r_idx <= r_idx + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.segment    = r_segment;
  assign bus.digit_sel  = r_digit_sel;
  assign bus.frame_tick = r_frame_tick;

endmodule
